// File: rtl/ar_arbiter_ctrl_pkg.sv
// Shared AR-channel field layout and arbiter state type for the master-side
// read-address arbiter.
package axi_ar_pkg;

  localparam int BURST_W   = 2;
  localparam int SIZE_W    = 3;
  localparam int LEN_W     = 4;
  localparam int ADDR_W    = 32;
  localparam int ID_W      = 4;

  localparam int BURST_OFF = 0;
  localparam int SIZE_OFF  = 2;
  localparam int LEN_OFF   = 5;
  localparam int ADDR_OFF  = 9;
  localparam int ID_OFF    = 41;

  localparam int AR_WORD_W = 45;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } ar_word_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_e;

  // Placement is driven by the offsets so the FIFO word layout has one source
  function automatic ar_word_t pack_ar(
    input logic [ID_W-1:0]    id,
    input logic [ADDR_W-1:0]  addr,
    input logic [LEN_W-1:0]   len,
    input logic [SIZE_W-1:0]  size,
    input logic [BURST_W-1:0] burst
  );
    logic [AR_WORD_W-1:0] w;
    w = '0;
    w[BURST_OFF +: BURST_W] = burst;
    w[SIZE_OFF  +: SIZE_W]  = size;
    w[LEN_OFF   +: LEN_W]   = len;
    w[ADDR_OFF  +: ADDR_W]  = addr;
    w[ID_OFF    +: ID_W]    = id;
    return ar_word_t'(w);
  endfunction

endpackage

// File: rtl/ar_arbiter_ctrl_if.sv
// Bundle of per-master AR requests, AR FIFO write port, read-completion
// feedback and status seen by the arbiter.
interface ar_arbiter_ctrl_if #(
  parameter int NUM_M    = 2,
  parameter int MAX_OUTS = 4
);
  import axi_ar_pkg::*;

  localparam int CW = $clog2(MAX_OUTS + 1);
  localparam int MW = $clog2(NUM_M);

  logic [NUM_M-1:0][ID_W-1:0]    m_arid;
  logic [NUM_M-1:0][ADDR_W-1:0]  m_araddr;
  logic [NUM_M-1:0][LEN_W-1:0]   m_arlen;
  logic [NUM_M-1:0][SIZE_W-1:0]  m_arsize;
  logic [NUM_M-1:0][BURST_W-1:0] m_arburst;
  logic [NUM_M-1:0]              m_arvalid;
  logic [NUM_M-1:0]              m_arready;
  logic                          fifo_wpush;
  logic [AR_WORD_W-1:0]          fifo_wdata;
  logic                          fifo_wfull;
  logic                          rdone_valid;
  logic [MW-1:0]                 rdone_mid;
  logic [NUM_M-1:0][CW-1:0]      outs_cnt;
  logic                          err_underflow;

  modport slave (
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
    input  fifo_wfull, rdone_valid, rdone_mid,
    output m_arready, fifo_wpush, fifo_wdata, outs_cnt, err_underflow
  );

  modport master (
    output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
    output fifo_wfull, rdone_valid, rdone_mid,
    input  m_arready, fifo_wpush, fifo_wdata, outs_cnt, err_underflow
  );

endinterface

// File: rtl/ar_arbiter_ctrl_rr_pick.sv
// Combinational round-robin search: first set request at or after ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Walk offsets from farthest to nearest so the nearest hit is written last
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      valid = valid | req[IW'((int'(ptr) + k) % N)];
      idx   = req[IW'((int'(ptr) + k) % N)] ? IW'((int'(ptr) + k) % N) : idx;
    end
  end

endmodule

// File: rtl/ar_arbiter_ctrl.sv
// Round-robin AR arbiter feeding one AR CDC FIFO write port, with a per-master
// outstanding-burst cap driven by read-completion feedback.
module ar_arbiter_ctrl
  import axi_ar_pkg::*;
#(
  parameter int NUM_M    = 2,
  parameter int MAX_OUTS = 4,
  parameter int CW       = $clog2(MAX_OUTS + 1)
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  ar_arbiter_ctrl_if.slave  bus
);

  localparam int MW = $clog2(NUM_M);

  arb_state_e               state_r, state_nxt_s;
  logic [MW-1:0]            gnt_r, gnt_nxt_s;
  logic [MW-1:0]            rr_ptr_r, rr_ptr_nxt_s;
  logic [NUM_M-1:0][CW-1:0] cnt_r, cnt_nxt_s;
  logic                     err_r, err_set_s;
  logic [NUM_M-1:0]         elig_s, dec_s, arready_s;
  logic                     pick_valid_s;
  logic [MW-1:0]            pick_idx_s;
  logic                     wpush_s;
  logic [AR_WORD_W-1:0]     wdata_s;

  // Per-master eligibility and completion decode
  always_comb begin
    elig_s = '0;
    dec_s  = '0;
    for (int i = 0; i < NUM_M; i++) begin
      elig_s[i] = bus.m_arvalid[i] && (cnt_r[i] < CW'(MAX_OUTS));
      dec_s[i]  = bus.rdone_valid && (bus.rdone_mid == MW'(i));
    end
  end

  rr_pick #(.N(NUM_M), .IW(MW)) u_pick (
    .req   (elig_s),
    .ptr   (rr_ptr_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // Next-state and FIFO/handshake outputs; ready is combinational with the push
  always_comb begin
    state_nxt_s  = state_r;
    gnt_nxt_s    = gnt_r;
    rr_ptr_nxt_s = rr_ptr_r;
    arready_s    = '0;
    wpush_s      = 1'b0;
    wdata_s      = '0;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          gnt_nxt_s   = pick_idx_s;
          state_nxt_s = SEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        wpush_s = bus.m_arvalid[gnt_r];
        wdata_s = pack_ar(bus.m_arid[gnt_r], bus.m_araddr[gnt_r], bus.m_arlen[gnt_r],
                          bus.m_arsize[gnt_r], bus.m_arburst[gnt_r]);
        if (bus.m_arvalid[gnt_r] && !bus.fifo_wfull) begin
          arready_s[gnt_r] = 1'b1;
          rr_ptr_nxt_s     = (gnt_r == MW'(NUM_M - 1)) ? '0 : gnt_r + MW'(1);
          state_nxt_s      = IDLE;
        end else if (!bus.m_arvalid[gnt_r]) begin
          // Master withdrew its request: abandon the grant without pushing
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Outstanding counters: simultaneous issue and completion cancel out
  always_comb begin
    cnt_nxt_s = cnt_r;
    err_set_s = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (arready_s[i] && !dec_s[i]) begin
        cnt_nxt_s[i] = cnt_r[i] + CW'(1);
      end else if (dec_s[i] && !arready_s[i]) begin
        if (cnt_r[i] == '0) begin
          err_set_s = 1'b1;
        end else begin
          cnt_nxt_s[i] = cnt_r[i] - CW'(1);
        end
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
    end
  end

  // State, grant, pointer, counter and sticky error registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_r  <= IDLE;
      gnt_r    <= '0;
      rr_ptr_r <= '0;
      cnt_r    <= '0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      gnt_r    <= gnt_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
      cnt_r    <= cnt_nxt_s;
      err_r    <= err_r | err_set_s;
    end
  end

  assign bus.m_arready     = arready_s;
  assign bus.fifo_wpush    = wpush_s;
  assign bus.fifo_wdata    = wdata_s;
  assign bus.outs_cnt      = cnt_r;
  assign bus.err_underflow = err_r;

endmodule

// File: tb/tb_ar_arbiter_ctrl.sv
// Directed and random checks of ar_arbiter_ctrl against a cycle-level
// reference model of the arbitration and outstanding-count rules.
module tb_ar_arbiter_ctrl;
  import axi_ar_pkg::*;

  localparam int NUM_M    = 2;
  localparam int MAX_OUTS = 4;
  localparam int CW       = 3;
  localparam logic [1:0] T2_EXP [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

  logic ACLK = 1'b0;
  logic ARESETn;

  always #5 ACLK = ~ACLK;

  ar_arbiter_ctrl_if #(.NUM_M(NUM_M), .MAX_OUTS(MAX_OUTS)) bus ();

  ar_arbiter_ctrl #(.NUM_M(NUM_M), .MAX_OUTS(MAX_OUTS)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // reference model: -1 means no master currently holds the grant
  int mdl_gnt;
  int mdl_ptr;
  int mdl_cnt [NUM_M];
  bit mdl_err;

  logic [NUM_M-1:0]         obs_ready;
  logic                     obs_push;
  logic [44:0]              obs_data;
  logic [NUM_M-1:0][CW-1:0] obs_cnt;
  logic                     obs_err;
  logic [44:0]              w_hold;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [44:0] exp_word(input int m);
    return {bus.m_arid[m], bus.m_araddr[m], bus.m_arlen[m], bus.m_arsize[m], bus.m_arburst[m]};
  endfunction

  task automatic model_reset();
    mdl_gnt = -1;
    mdl_ptr = 0;
    for (int i = 0; i < NUM_M; i++) mdl_cnt[i] = 0;
    mdl_err = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.m_arvalid   = '0;
    bus.m_arid      = '0;
    bus.m_araddr    = '0;
    bus.m_arlen     = '0;
    bus.m_arsize    = '0;
    bus.m_arburst   = '0;
    bus.fifo_wfull  = 1'b0;
    bus.rdone_valid = 1'b0;
    bus.rdone_mid   = '0;
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    model_reset();
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
  endtask

  // One clock cycle: compare outputs with the model, then advance the model at the edge
  task automatic cyc();
    logic [NUM_M-1:0]         e_ready;
    logic                     e_push;
    logic [44:0]              e_data;
    logic [NUM_M-1:0][CW-1:0] e_cnt;
    bit                       hs;
    int                       g;
    bit                       found;
    #1;
    e_ready = '0;
    e_push  = 1'b0;
    e_data  = '0;
    if (mdl_gnt >= 0) begin
      e_push = bus.m_arvalid[mdl_gnt];
      e_data = exp_word(mdl_gnt);
      if (bus.m_arvalid[mdl_gnt] && !bus.fifo_wfull) e_ready[mdl_gnt] = 1'b1;
    end
    for (int i = 0; i < NUM_M; i++) e_cnt[i] = CW'(mdl_cnt[i]);
    obs_ready = bus.m_arready;
    obs_push  = bus.fifo_wpush;
    obs_data  = bus.fifo_wdata;
    obs_cnt   = bus.outs_cnt;
    obs_err   = bus.err_underflow;
    chk("arready", obs_ready, e_ready);
    chk("wpush", obs_push, e_push);
    chk("wdata", obs_data, e_data);
    chk("outs_cnt", obs_cnt, e_cnt);
    chk("err_underflow", obs_err, mdl_err);
    @(posedge ACLK);
    hs = (mdl_gnt >= 0) && bus.m_arvalid[mdl_gnt] && !bus.fifo_wfull;
    g  = mdl_gnt;
    if (g >= 0) begin
      if (hs) mdl_ptr = (g + 1) % NUM_M;
      if (hs || !bus.m_arvalid[g]) mdl_gnt = -1;
    end else begin
      found = 1'b0;
      for (int k = 0; k < NUM_M; k++) begin
        int j;
        j = (mdl_ptr + k) % NUM_M;
        if (!found && bus.m_arvalid[j] && mdl_cnt[j] < MAX_OUTS) begin
          mdl_gnt = j;
          found   = 1'b1;
        end
      end
    end
    for (int i = 0; i < NUM_M; i++) begin
      bit inc, dec;
      inc = hs && (g == i);
      dec = bus.rdone_valid && (int'(bus.rdone_mid) == i);
      if (inc && !dec) mdl_cnt[i]++;
      else if (dec && !inc) begin
        if (mdl_cnt[i] == 0) mdl_err = 1'b1;
        else mdl_cnt[i]--;
      end
    end
    @(negedge ACLK);
  endtask

  initial begin
    idle_inputs();
    ARESETn = 1'b0;
    model_reset();
    @(negedge ACLK);
    #1;
    chk("rst_arready", bus.m_arready, 2'b00);
    chk("rst_wpush", bus.fifo_wpush, 1'b0);
    chk("rst_outs_cnt", bus.outs_cnt, 6'd0);
    chk("rst_err", bus.err_underflow, 1'b0);
    @(negedge ACLK);
    ARESETn = 1'b1;

    // single request into an empty FIFO
    bus.m_arvalid    = 2'b01;
    bus.m_arid[0]    = 4'h3;
    bus.m_araddr[0]  = 32'h1000_0040;
    bus.m_arlen[0]   = 4'h3;
    bus.m_arsize[0]  = 3'h2;
    bus.m_arburst[0] = 2'h1;
    cyc();
    chk("t1_c0_ready", obs_ready, 2'b00);
    cyc();
    chk("t1_wpush", obs_push, 1'b1);
    chk("t1_ready", obs_ready, 2'b01);
    chk("t1_wdata", obs_data, {4'h3, 32'h1000_0040, 4'h3, 3'h2, 2'h1});
    chk("t1_cnt_before", obs_cnt[0], 3'd0);
    bus.m_arvalid = 2'b00;
    cyc();
    chk("t1_cnt_after", obs_cnt[0], 3'd1);

    // fairness with both masters continuously valid
    do_reset();
    bus.m_arvalid = 2'b11;
    for (int c = 0; c < 8; c++) begin
      cyc();
      chk("t2_order", obs_ready, T2_EXP[c]);
    end
    bus.m_arvalid = 2'b00;
    cyc();
    chk("t2_cnts", obs_cnt, {3'd2, 3'd2});

    // FIFO backpressure for three SEND cycles
    do_reset();
    for (int i = 0; i < NUM_M; i++) begin
      bus.m_arid[i]    = 4'($urandom());
      bus.m_araddr[i]  = $urandom();
      bus.m_arlen[i]   = 4'($urandom());
      bus.m_arsize[i]  = 3'($urandom());
      bus.m_arburst[i] = 2'($urandom());
    end
    bus.m_arvalid  = 2'b11;
    bus.fifo_wfull = 1'b1;
    w_hold = {bus.m_arid[0], bus.m_araddr[0], bus.m_arlen[0], bus.m_arsize[0], bus.m_arburst[0]};
    cyc();
    for (int c = 1; c <= 3; c++) begin
      cyc();
      chk("t3_push_held", obs_push, 1'b1);
      chk("t3_ready_low", obs_ready, 2'b00);
      chk("t3_data_stable", obs_data, w_hold);
    end
    bus.fifo_wfull = 1'b0;
    cyc();
    chk("t3_release_ready", obs_ready, 2'b01);
    chk("t3_release_data", obs_data, w_hold);
    bus.m_arvalid = 2'b00;
    cyc();

    // outstanding cap on master 0
    do_reset();
    bus.m_arvalid = 2'b01;
    for (int c = 0; c < 8; c++) cyc();
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk("t4_capped", obs_ready, 2'b00);
      chk("t4_cnt_max", obs_cnt[0], 3'd4);
    end
    bus.rdone_valid = 1'b1;
    bus.rdone_mid   = 1'b0;
    cyc();
    bus.rdone_valid = 1'b0;
    cyc();
    chk("t4_regrant_idle", obs_ready, 2'b00);
    cyc();
    chk("t4_regrant", obs_ready, 2'b01);

    // simultaneous issue/completion on master 1, then underflow
    bus.m_arvalid = 2'b10;
    cyc();
    cyc();
    chk("t5_hs1", obs_ready, 2'b10);
    cyc();
    bus.rdone_valid = 1'b1;
    bus.rdone_mid   = 1'b1;
    cyc();
    chk("t5_hs2", obs_ready, 2'b10);
    bus.m_arvalid   = 2'b00;
    bus.rdone_valid = 1'b0;
    cyc();
    chk("t5_cnt_same", obs_cnt[1], 3'd1);
    bus.rdone_valid = 1'b1;
    cyc();
    cyc();
    chk("t5_cnt_zero", obs_cnt[1], 3'd0);
    chk("t5_err_not_yet", obs_err, 1'b0);
    bus.rdone_valid = 1'b0;
    cyc();
    chk("t5_err_set", obs_err, 1'b1);
    cyc();
    chk("t5_err_sticky", obs_err, 1'b1);

    // asynchronous reset while SEND is stalled
    do_reset();
    bus.m_arvalid = 2'b01;
    cyc();
    cyc();
    bus.m_arvalid  = 2'b10;
    bus.fifo_wfull = 1'b1;
    cyc();
    #1;
    chk("t6_pre_push", bus.fifo_wpush, 1'b1);
    #1;
    ARESETn = 1'b0;
    model_reset();
    #1;
    chk("t6_push_drop", bus.fifo_wpush, 1'b0);
    chk("t6_ready_drop", bus.m_arready, 2'b00);
    chk("t6_cnt_clear", bus.outs_cnt, 6'd0);
    @(negedge ACLK);
    ARESETn        = 1'b1;
    bus.fifo_wfull = 1'b0;
    bus.m_arvalid  = 2'b11;
    cyc();
    cyc();
    chk("t6_first_m0", obs_ready, 2'b01);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.m_arvalid = 2'($urandom_range(0, 3));
      for (int i = 0; i < NUM_M; i++) begin
        bus.m_arid[i]    = 4'($urandom());
        bus.m_araddr[i]  = $urandom();
        bus.m_arlen[i]   = 4'($urandom());
        bus.m_arsize[i]  = 3'($urandom());
        bus.m_arburst[i] = 2'($urandom());
      end
      bus.fifo_wfull  = ($urandom_range(0, 3) == 0);
      bus.rdone_valid = ($urandom_range(0, 2) == 0);
      bus.rdone_mid   = 1'($urandom_range(0, 1));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
